// File: rtl/alu_issue_pkg.sv
// Shared types and widths for the ALU issue controller: FSM states,
// datapath widths and the packed command word stored in the FIFO.
package alu_issue_pkg;

    localparam int OP_W   = 8;
    localparam int SEL_W  = 4;
    localparam int MUL_W  = 16;
    localparam int CNT_W  = 16;
    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]  a;
        logic [OP_W-1:0]  b;
        logic [SEL_W-1:0] sel;
    } cmd_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Command, ALU and response signals of the issue controller bundled as one
// interface; slave is the controller side, master the environment side.
interface alu_issue_ctrl_if;
    import alu_issue_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [OP_W-1:0]  cmd_a;
    logic [OP_W-1:0]  cmd_b;
    logic [SEL_W-1:0] cmd_sel;

    logic [OP_W-1:0]  alu_a;
    logic [OP_W-1:0]  alu_b;
    logic [SEL_W-1:0] alu_select;
    logic [OP_W-1:0]  alu_out;
    logic [MUL_W-1:0] alu_mul;
    logic             alu_carry;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [OP_W-1:0]  rsp_out;
    logic [MUL_W-1:0] rsp_mul;
    logic             rsp_carry;
    logic [SEL_W-1:0] rsp_sel;

    logic             busy;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_sel,
        input  alu_out, alu_mul, alu_carry,
        input  rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_select,
        output rsp_valid, rsp_out, rsp_mul, rsp_carry, rsp_sel, busy
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_sel,
        output alu_out, alu_mul, alu_carry,
        output rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_select,
        input  rsp_valid, rsp_out, rsp_mul, rsp_carry, rsp_sel, busy
    );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Command FIFO with extra-bit pointers; the head is read straight from the
// array, so a command pushed on an edge is never visible to a pop on that edge.
module alu_cmd_fifo
    import alu_issue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_i,
    input  cmd_t push_data_i,
    input  logic pop_i,
    output cmd_t pop_data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);

    cmd_t          mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          do_push, do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Queues ALU commands, launches them one at a time and holds each result until
// accepted. Define ALU_ISSUE_STATS_EN to add the stat_ops/stat_carry counters.
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_issue_ctrl_if.slave      bus
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [CNT_W-1:0]     stat_ops,
    output logic [CNT_W-1:0]     stat_carry
`endif
);

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [OP_W-1:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [SEL_W-1:0]   alu_sel_q, alu_sel_d;
    logic [OP_W-1:0]    rsp_out_q, rsp_out_d;
    logic [MUL_W-1:0]   rsp_mul_q, rsp_mul_d;
    logic               rsp_carry_q, rsp_carry_d;
    logic [SEL_W-1:0]   rsp_sel_q, rsp_sel_d;

    logic fifo_full, fifo_empty, fifo_pop;
    cmd_t push_cmd, head_cmd;

    assign push_cmd = {bus.cmd_a, bus.cmd_b, bus.cmd_sel};

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (bus.cmd_valid && !fifo_full),
        .push_data_i (push_cmd),
        .pop_i       (fifo_pop),
        .pop_data_o  (head_cmd),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        rsp_out_d   = rsp_out_q;
        rsp_mul_d   = rsp_mul_q;
        rsp_carry_d = rsp_carry_q;
        rsp_sel_d   = rsp_sel_q;
        fifo_pop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    alu_a_d   = head_cmd.a;
                    alu_b_d   = head_cmd.b;
                    alu_sel_d = head_cmd.sel;
                    wait_d    = WAIT_W'(ALU_LAT);
                    state_d   = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                wait_d = wait_q - WAIT_W'(1);
                // The ALU result is sampled on the last counted cycle only.
                if (wait_q == WAIT_W'(1)) begin
                    rsp_out_d   = bus.alu_out;
                    rsp_mul_d   = bus.alu_mul;
                    rsp_carry_d = bus.alu_carry;
                    rsp_sel_d   = alu_sel_q;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            rsp_out_q   <= '0;
            rsp_mul_q   <= '0;
            rsp_carry_q <= 1'b0;
            rsp_sel_q   <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            rsp_out_q   <= rsp_out_d;
            rsp_mul_q   <= rsp_mul_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_sel_q   <= rsp_sel_d;
        end
    end

    assign bus.cmd_ready  = !fifo_full;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_select = alu_sel_q;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_out    = rsp_out_q;
    assign bus.rsp_mul    = rsp_mul_q;
    assign bus.rsp_carry  = rsp_carry_q;
    assign bus.rsp_sel    = rsp_sel_q;
    assign bus.busy       = (state_q != IDLE) || !fifo_empty;

`ifdef ALU_ISSUE_STATS_EN
    logic [CNT_W-1:0] ops_q, ops_d, carry_q, carry_d;
    logic             rsp_hs;

    assign rsp_hs = (state_q == RESP) && bus.rsp_ready;

    // Both counters stick at all-ones instead of wrapping.
    always_comb begin
        ops_d   = ops_q;
        carry_d = carry_q;
        if (rsp_hs && (ops_q != '1)) ops_d = ops_q + CNT_W'(1);
        if (rsp_hs && rsp_carry_q && (carry_q != '1)) carry_d = carry_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ops_q   <= '0;
            carry_q <= '0;
        end else begin
            ops_q   <= ops_d;
            carry_q <= carry_d;
        end
    end

    assign stat_ops   = ops_q;
    assign stat_carry = carry_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: one instance with ALU_LAT=1 and one with
// ALU_LAT=3 driven by a slow-settling ALU model; monitors pop expected responses.
module tb_alu_issue_ctrl;
    import alu_issue_pkg::*;

    typedef struct packed {
        logic [7:0]  out;
        logic [15:0] mul;
        logic        carry;
        logic [3:0]  sel;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    bit sawNotReady = 1'b0;
    rsp_t q1[$];
    rsp_t q3[$];

    alu_issue_ctrl_if b1 ();
    alu_issue_ctrl_if b3 ();

`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] statOps1, statCarry1, statOps3, statCarry3;
`endif

    alu_issue_ctrl #(.DEPTH(4), .ALU_LAT(1)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (b1.slave)
`ifdef ALU_ISSUE_STATS_EN
        ,
        .stat_ops   (statOps1),
        .stat_carry (statCarry1)
`endif
    );

    alu_issue_ctrl #(.DEPTH(4), .ALU_LAT(3)) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (b3.slave)
`ifdef ALU_ISSUE_STATS_EN
        ,
        .stat_ops   (statOps3),
        .stat_carry (statCarry3)
`endif
    );

    // Reference ALU: 9-bit sum with select folded in, product xor'd with select.
    function automatic rsp_t aluFn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
        logic [8:0] sum;
        rsp_t r;
        sum = {1'b0, a} + {1'b0, b} + {5'b0, s};
        r.out = sum[7:0] ^ {s, s};
        r.mul = (16'(a) * 16'(b)) ^ {s, 12'h000};
        r.carry = sum[8];
        r.sel = s;
        return r;
    endfunction

    rsp_t m1;
    assign m1 = aluFn(b1.alu_a, b1.alu_b, b1.alu_select);
    assign b1.alu_out = m1.out;
    assign b1.alu_mul = m1.mul;
    assign b1.alu_carry = m1.carry;

    // Slow ALU: output is junk from launch+1 until the operands reach stage 3.
    cmd_t s1 = '0, s2 = '0, s3 = '0;
    rsp_t m3;
    always @(posedge clk) begin
        s1 <= {b3.alu_a, b3.alu_b, b3.alu_select};
        s2 <= s1;
        s3 <= s2;
    end
    always_comb begin
        m3 = aluFn(s3.a, s3.b, s3.sel);
        if (s1 != s3) begin
            m3 = aluFn(s1.a, s1.b, s1.sel);
            m3.out = m3.out ^ 8'hA5;
            m3.mul = m3.mul ^ 16'h5A5A;
            m3.carry = ~m3.carry;
        end
    end
    assign b3.alu_out = m3.out;
    assign b3.alu_mul = m3.mul;
    assign b3.alu_carry = m3.carry;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int inst, input logic [7:0] a, input logic [7:0] b,
                                 input logic [3:0] s, input bit expectRsp, input rsp_t exp);
        int waitCycles = 0;
        logic rdy;
        if (inst == 1) begin
            b1.cmd_valid = 1'b1; b1.cmd_a = a; b1.cmd_b = b; b1.cmd_sel = s;
        end else begin
            b3.cmd_valid = 1'b1; b3.cmd_a = a; b3.cmd_b = b; b3.cmd_sel = s;
        end
        rdy = (inst == 1) ? b1.cmd_ready : b3.cmd_ready;
        while (!rdy && waitCycles < 200) begin
            sawNotReady = 1'b1;
            waitCycles++;
            @(negedge clk);
            rdy = (inst == 1) ? b1.cmd_ready : b3.cmd_ready;
        end
        if (!rdy) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL push_timeout: cmd_ready stuck 0, expected 1");
        end else begin
            if (expectRsp) begin
                if (inst == 1) q1.push_back(exp);
                else q3.push_back(exp);
            end
            @(posedge clk);
        end
        @(negedge clk);
        b1.cmd_valid = 1'b0;
        b3.cmd_valid = 1'b0;
    endtask

    task automatic waitDrain(input int inst);
        int n = 0;
        while (n < 500 && ((inst == 1) ? (q1.size() != 0 || b1.busy) : (q3.size() != 0 || b3.busy))) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain_timeout: inst %0d still busy, expected idle", inst);
        end
    endtask

    // Monitors sample mid-low-phase, after any negedge stimulus update.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && b1.rsp_valid) begin
            if (q1.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL rsp1_unexpected: got 0x%0h, expected no response",
                         {b1.rsp_out, b1.rsp_mul, b1.rsp_carry, b1.rsp_sel});
            end else begin
                checkOutput("rsp1", 32'({b1.rsp_out, b1.rsp_mul, b1.rsp_carry, b1.rsp_sel}), 32'(q1[0]));
                if (b1.rsp_ready) void'(q1.pop_front());
            end
        end
    end

    always begin
        @(negedge clk);
        #2;
        if (rst_n && b3.rsp_valid) begin
            if (q3.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL rsp3_unexpected: got 0x%0h, expected no response",
                         {b3.rsp_out, b3.rsp_mul, b3.rsp_carry, b3.rsp_sel});
            end else begin
                checkOutput("rsp3", 32'({b3.rsp_out, b3.rsp_mul, b3.rsp_carry, b3.rsp_sel}), 32'(q3[0]));
                if (b3.rsp_ready) void'(q3.pop_front());
            end
        end
    end

    initial begin
        b1.cmd_valid = 1'b0; b1.cmd_a = '0; b1.cmd_b = '0; b1.cmd_sel = '0; b1.rsp_ready = 1'b1;
        b3.cmd_valid = 1'b0; b3.cmd_a = '0; b3.cmd_b = '0; b3.cmd_sel = '0; b3.rsp_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 32'(b1.busy), 32'd0);
        checkOutput("reset_rsp_valid", 32'(b1.rsp_valid), 32'd0);
        checkOutput("reset_cmd_ready", 32'(b1.cmd_ready), 32'd1);
        checkOutput("reset_alu_a", 32'(b1.alu_a), 32'd0);
        checkOutput("reset_rsp_mul", 32'(b1.rsp_mul), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] single op latency");
        applyStimulus(1, 8'h58, 8'h06, 4'h0, 1'b1, '{8'h5E, 16'h0210, 1'b0, 4'h0});
        @(negedge clk);
        @(negedge clk);
        checkOutput("lat1_early", 32'(b1.rsp_valid), 32'd0);
        @(negedge clk);
        checkOutput("lat1_valid", 32'(b1.rsp_valid), 32'd1);
        waitDrain(1);

        $display("[TB] select sweep");
        sawNotReady = 1'b0;
        for (int s = 0; s < 16; s++)
            applyStimulus(1, 8'h58, 8'h06, 4'(s), 1'b1, aluFn(8'h58, 8'h06, 4'(s)));
        checkOutput("sweep_backpressure_seen", 32'(sawNotReady), 32'd1);
        waitDrain(1);
        checkOutput("sweep_cmd_ready", 32'(b1.cmd_ready), 32'd1);
        checkOutput("sweep_busy", 32'(b1.busy), 32'd0);

        $display("[TB] response backpressure");
        b1.rsp_ready = 1'b0;
        applyStimulus(1, 8'h10, 8'h20, 4'h1, 1'b1, '{8'h20, 16'h1200, 1'b0, 4'h1});
        applyStimulus(1, 8'h01, 8'h02, 4'h2, 1'b1, '{8'h27, 16'h2002, 1'b0, 4'h2});
        applyStimulus(1, 8'hFF, 8'h01, 4'h0, 1'b1, '{8'h00, 16'h00FF, 1'b1, 4'h0});
        applyStimulus(1, 8'hF0, 8'h20, 4'h3, 1'b1, '{8'h20, 16'h2E00, 1'b1, 4'h3});
        applyStimulus(1, 8'h58, 8'h06, 4'h5, 1'b1, aluFn(8'h58, 8'h06, 4'h5));
        repeat (10) @(negedge clk);
        checkOutput("bp_cmd_ready", 32'(b1.cmd_ready), 32'd0);
        checkOutput("bp_rsp_valid", 32'(b1.rsp_valid), 32'd1);
        b1.rsp_ready = 1'b1;
        waitDrain(1);

        $display("[TB] slow ALU, ALU_LAT=3");
        applyStimulus(3, 8'hF0, 8'h20, 4'h3, 1'b1, '{8'h20, 16'h2E00, 1'b1, 4'h3});
        repeat (4) @(negedge clk);
        checkOutput("lat3_early", 32'(b3.rsp_valid), 32'd0);
        @(negedge clk);
        checkOutput("lat3_valid", 32'(b3.rsp_valid), 32'd1);
        waitDrain(3);

        $display("[TB] reset during WAIT");
        applyStimulus(1, 8'h11, 8'h22, 4'h1, 1'b0, '0);
        applyStimulus(1, 8'h33, 8'h44, 4'h2, 1'b0, '0);
        applyStimulus(1, 8'h55, 8'h66, 4'h3, 1'b0, '0);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rst_busy", 32'(b1.busy), 32'd0);
        checkOutput("rst_rsp_valid", 32'(b1.rsp_valid), 32'd0);
        checkOutput("rst_cmd_ready", 32'(b1.cmd_ready), 32'd1);
        checkOutput("rst_alu_select", 32'(b1.alu_select), 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("rst_stays_idle", 32'(b1.busy), 32'd0);

`ifdef ALU_ISSUE_STATS_EN
        $display("[TB] statistics");
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1, 8'h58, 8'h06, 4'h0, 1'b1, '{8'h5E, 16'h0210, 1'b0, 4'h0});
        applyStimulus(1, 8'hF0, 8'h20, 4'h3, 1'b1, '{8'h20, 16'h2E00, 1'b1, 4'h3});
        applyStimulus(1, 8'h10, 8'h20, 4'h1, 1'b1, '{8'h20, 16'h1200, 1'b0, 4'h1});
        applyStimulus(1, 8'hFF, 8'h01, 4'h0, 1'b1, '{8'h00, 16'h00FF, 1'b1, 4'h0});
        applyStimulus(1, 8'h01, 8'h02, 4'h2, 1'b1, '{8'h27, 16'h2002, 1'b0, 4'h2});
        waitDrain(1);
        checkOutput("stat_ops", 32'(statOps1), 32'd5);
        checkOutput("stat_carry", 32'(statCarry1), 32'd2);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
